seq_restoring_divider: RTL

//  - Sequential unsigned restoring divider. Computes the quotient and remainder of
//    o_quotient = i_dividend / i_divisor and o_remainder = i_dividend % i_divisor.
//  - It is the inverse-direction companion of the Wallace tree multiplier.
//  - It reuses the team's full_adder cells as a ripple subtractor and produces one

---
 rtl/seq_restoring_divider_pkg.sv | 12 +
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider_subtractor.sv | 37 +++
 rtl/seq_restoring_divider.sv | 100 ++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM encoding and default operand width.
package seq_restoring_divider_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bundle between a requester (master) and the divider (slave).
interface seq_restoring_divider_if
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             i_start;
   logic [WIDTH-1:0] i_dividend;
   logic [WIDTH-1:0] i_divisor;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_quotient;
   logic [WIDTH-1:0] o_remainder;
   logic             o_div_by_zero;

   modport master (
      output i_start, i_dividend, i_divisor,
      input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
   );

   modport slave (
      input  i_start, i_dividend, i_divisor,
      output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider_subtractor.sv
// Ripple subtractor a - b = a + ~b + 1 built from full_adder cells; purely combinational.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_subtractor #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);
   logic [N:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (~b[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // No carry out of the top cell means b > a.
   assign borrow = ~carry[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; o_done WIDTH cycles after start (1 on /0).
// Requests are only sampled in IDLE or DONE; i_start during RUN is dropped.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvsr;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             take;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] r_nxt;

   // R is always below the divisor, so its top bit is never stored.
   assign shifted = {r, q[WIDTH-1]};

   ripple_subtractor #(.N(WIDTH + 1)) u_sub (
      .a      (shifted),
      .b      ({1'b0, dvsr}),
      .diff   (diff),
      .borrow (borrow)
   );

   // For in-range operands diff[WIDTH] mirrors borrow; either one blocks the restore.
   assign take  = ~(borrow | diff[WIDTH]);
   assign q_nxt = {q[WIDTH-2:0], take};
   assign r_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state             <= IDLE;
         count             <= '0;
         r                 <= '0;
         q                 <= '0;
         dvsr              <= '0;
         bus.o_busy        <= 1'b0;
         bus.o_done        <= 1'b0;
         bus.o_quotient    <= '0;
         bus.o_remainder   <= '0;
         bus.o_div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  dvsr              <= bus.i_divisor;
                  q                 <= bus.i_dividend;
                  r                 <= '0;
                  count             <= CW'(WIDTH - 1);
                  bus.o_div_by_zero <= 1'b0;
                  if (bus.i_divisor == '0) begin
                     state             <= DONE;
                     bus.o_busy        <= 1'b0;
                     bus.o_done        <= 1'b1;
                     bus.o_quotient    <= '1;
                     bus.o_remainder   <= bus.i_dividend;
                     bus.o_div_by_zero <= 1'b1;
                  end else begin
                     state      <= RUN;
                     bus.o_busy <= 1'b1;
                     bus.o_done <= 1'b0;
                  end
               end else begin
                  state      <= IDLE;
                  bus.o_done <= 1'b0;
               end
            end
            RUN: begin
               r     <= r_nxt;
               q     <= q_nxt;
               count <= count - CW'(1);
               if (count == '0) begin
                  state           <= DONE;
                  bus.o_busy      <= 1'b0;
                  bus.o_done      <= 1'b1;
                  bus.o_quotient  <= q_nxt;
                  bus.o_remainder <= r_nxt;
               end
            end
            default: begin
               state      <= IDLE;
               bus.o_busy <= 1'b0;
               bus.o_done <= 1'b0;
            end
         endcase
      end
   end
endmodule
